// File: rtl/mips_dbg_pkg.sv
// Shared encodings for the mips debug port: command ops, FSM states and
// the position of the timeout flag in a RUN response.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    OP_MEMWR  = 2'b00,
    OP_REGRD  = 2'b01,
    OP_RUN    = 2'b10,
    OP_STATUS = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEMWR,
    ST_RDADDR,
    ST_RDCAP,
    ST_CLR,
    ST_RUN,
    ST_RESP
  } state_e;

  localparam int TIMEOUT_BIT = 31;

endpackage

// File: rtl/mips_dbg_cyc_cnt.sv
// Saturating run-cycle counter. 'count' already includes the current
// enabled cycle, so the caller can report it at the same edge it stops.
module mips_dbg_cyc_cnt #(
  parameter int              CW      = 16,
  parameter logic [CW-1:0]   MAX_CYC = 16'hFFFF
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          at_max
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != MAX_CYC)) begin
      count_d = count_q + CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count  = count_d;
  assign at_max = (count_d == MAX_CYC);

endmodule

// File: rtl/mips_dbg_port.sv
// Host-side load/run/dump controller for the mips core: accepts commands,
// writes instruction memory, reads registers and times runs to halt.
module mips_dbg_port
  import mips_dbg_pkg::*;
#(
  parameter int            AW      = 10,
  parameter int            DW      = 32,
  parameter int            RW      = 5,
  parameter int            CW      = 16,
  parameter logic [CW-1:0] MAX_CYC = 16'hFFFF
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [RW-1:0] reg_raddr,
  input  logic [DW-1:0] reg_rdata,
  output logic          core_clr,
  output logic          core_run,
  input  logic          core_halted
);

  state_e        state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [RW-1:0] reg_raddr_q, reg_raddr_d;
  logic          core_clr_q, core_clr_d;
  logic          core_run_q, core_run_d;
  logic          last_to_q, last_to_d;

  logic          cnt_clr, cnt_en, cnt_at_max;
  logic [CW-1:0] cnt_val;
  logic [DW-1:0] run_word, status_word;
  op_e           op;

  assign op = op_e'(cmd_op);

  mips_dbg_cyc_cnt #(
    .CW      (CW),
    .MAX_CYC (MAX_CYC)
  ) u_cnt (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .count  (cnt_val),
    .at_max (cnt_at_max)
  );

  // A halt in the timeout cycle is a clean halt, not a timeout.
  always_comb begin
    run_word                 = '0;
    run_word[CW-1:0]         = cnt_val;
    run_word[TIMEOUT_BIT]    = cnt_at_max & ~core_halted;
    status_word              = '0;
    status_word[0]           = core_halted;
    status_word[1]           = last_to_q;
    status_word[CW+1:2]      = cnt_val;
  end

  // NOTE: every signal assigned here gets a default first, otherwise a
  // path that skips it would infer a latch.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    reg_raddr_d = reg_raddr_q;
    core_clr_d  = 1'b0;
    core_run_d  = 1'b0;
    last_to_d   = last_to_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          unique case (op)
            OP_MEMWR: begin
              state_d     = ST_MEMWR;
              mem_we_d    = 1'b1;
              mem_addr_d  = cmd_addr;
              mem_wdata_d = cmd_data;
            end
            OP_REGRD: begin
              state_d     = ST_RDADDR;
              reg_raddr_d = cmd_addr[RW-1:0];
            end
            OP_RUN: begin
              state_d    = ST_CLR;
              core_clr_d = 1'b1;
            end
            OP_STATUS: begin
              state_d     = ST_RESP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = status_word;
            end
          endcase
        end
      end
      ST_MEMWR: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
      ST_RDADDR: state_d = ST_RDCAP;
      ST_RDCAP: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = reg_rdata;
      end
      ST_CLR: begin
        state_d    = ST_RUN;
        cnt_clr    = 1'b1;
        core_run_d = 1'b1;
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (core_halted || cnt_at_max) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = run_word;
          last_to_d   = run_word[TIMEOUT_BIT];
        end else begin
          core_run_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  // NOTE: every control and datapath flop is reset so that an abort in any
  // state leaves no stale strobe, run enable or response behind.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      reg_raddr_q <= '0;
      core_clr_q  <= 1'b0;
      core_run_q  <= 1'b0;
      last_to_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      reg_raddr_q <= reg_raddr_d;
      core_clr_q  <= core_clr_d;
      core_run_q  <= core_run_d;
      last_to_q   <= last_to_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign reg_raddr = reg_raddr_q;
  assign core_clr  = core_clr_q;
  assign core_run  = core_run_q;

endmodule
